gtfraw_vnc_status_qualifier: RTL
================================

# gtfraw_vnc_status_qualifier

Debounces and qualifies multi-bit status levels that have already been brought into the `clk` domain by the level synchronizer, such as GTF RX block lock, link up and PLL lock. Each bit gets a glitch filter plus one-cycle rise/fall pulses, latched-low/latched-high sticky bits and a saturating transition counter. It sits directly downstream of the level synchronizer and feeds the status/AXI register block.

## Interface
Parameters:
- `WIDTH`, 1: number of independent status bits.
- `STABLE_CYCLES`, 16: consecutive differing samples required to accept a change; legal range 1..65535.
- `CNT_WIDTH`, 16: width of each per-bit transition counter; minimum 1.
- `RESET_VALUE`, 1'b0: qualified level of every bit after reset.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high reset.
- `datain`  in  WIDTH: status levels, already synchronous to `clk`.
- `stat_clear`  in  1: single-cycle request to clear sticky bits and counters.
- `dataout`  out  WIDTH: qualified (debounced) levels.
- `rise`  out  WIDTH: one-cycle pulse when a qualified bit goes 0→1.
- `fall`  out  WIDTH: one-cycle pulse when a qualified bit goes 1→0.
- `sticky_low`  out  WIDTH: set if the qualified bit was 0 at any time since the last clear.
- `sticky_high`  out  WIDTH: set if the qualified bit was 1 at any time since the last clear.
- `change_cnt`  out  WIDTH*CNT_WIDTH: saturating count of qualified transitions; bit i occupies `[i*CNT_WIDTH +: CNT_WIDTH]`.

## Operation
- Each bit is fully independent and has a two-state FSM:
  - **STABLE**: if `datain[i]==dataout[i]`, stay in STABLE with the filter count at 0. If they differ, go to PENDING with the filter count at 1. When STABLE_CYCLES==1, instead update `dataout[i]` immediately and stay in STABLE.
  - **PENDING**: if `datain[i]` differs and the filter count is below STABLE_CYCLES-1, increment the count. If it differs and the count equals STABLE_CYCLES-1, load `dataout[i]` with `datain[i]`, pulse `rise`/`fall`, and return to STABLE with the count at 0. If `datain[i]` matches again, return to STABLE with the count at 0 (glitch rejected, no pulse, no counter change).
- Filter counter width is `$clog2(STABLE_CYCLES+1)`. It never wraps.
- Sticky bits:
  - `sticky_low` next value = (`stat_clear` ? 0 : `sticky_low`) | ~`dataout_next`.
  - `sticky_high` next value = (`stat_clear` ? 0 : `sticky_high`) | `dataout_next`.
  - If a clear and an event land in the same cycle, the event wins: after the clear, the bit reflects the current qualified level.
- Change counter:
  - Increments by 1 on each qualified transition and holds at all-ones (saturates).
  - `stat_clear` loads 0, or loads 1 if a transition commits in the same cycle.
- Reset values:
  - `dataout` = `{WIDTH{RESET_VALUE}}`.
  - `rise` = `fall` = 0.
  - `change_cnt` = 0.
  - `sticky_low` = `{WIDTH{~RESET_VALUE}}`, `sticky_high` = `{WIDTH{RESET_VALUE}}`.
  - Every FSM is in STABLE with the filter count at 0.
- Reset asserted mid-PENDING discards the pending change and produces no pulse.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Acceptance timing: `datain[i]` first differs at sampling edge k and then holds. `dataout[i]` changes at edge k+STABLE_CYCLES-1, and `rise`/`fall` are high for exactly the cycle following that edge, coincident with the new `dataout`.
- Worst-case end-to-end latency, including the 3-flop upstream synchronizer, is 3+STABLE_CYCLES cycles.
- A gap (one matching sample) restarts the count; the edge count above begins again from the next differing sample.
- `rise` and `fall` for the same bit are never high together. Back-to-back transitions are at least STABLE_CYCLES cycles apart.
- `stat_clear` takes effect on the edge at which it is sampled. Sticky and counter outputs reflect it in the next cycle.

## Structure
- Shared package `gtfraw_vnc_status_pkg` holds:
  - `typedef enum logic {ST_STABLE, ST_PENDING} status_state_t`.
  - A function returning the filter-counter width from STABLE_CYCLES.
- Sub-module `gtfraw_vnc_status_bit` implements one bit (FSM, filter counter, pulses, sticky bits, change counter). The top instantiates it WIDTH times in a generate loop and contains only generate wiring.

## Test plan
- Reset, STABLE_CYCLES=4, RESET_VALUE=0: after release, `dataout`=0, `sticky_low`=1, `sticky_high`=0, `change_cnt`=0, no pulses for 20 cycles.
- Glitch rejection: `datain` high for 3 cycles, then low (STABLE_CYCLES=4) → `dataout` stays 0, no `rise`, `change_cnt`=0.
- Acceptance: `datain` rises at edge 10 and holds → `dataout`=1 after edge 13, `rise` high for one cycle, `sticky_high`=1, `change_cnt`=1. Then drop low → `fall` pulse, `change_cnt`=2.
- Saturation: CNT_WIDTH=2, STABLE_CYCLES=1, toggle `datain` 6 times → `change_cnt` holds at 3.
- Clear collision: `stat_clear` on the cycle a 1→0 commits → `change_cnt`=1, `sticky_low`=1, `sticky_high`=0.
- Reset mid-PENDING: `datain` differs for 2 of 4 cycles, then `reset` pulses → `dataout`=RESET_VALUE, no pulse. Check that the filter restarts from 1 once `reset` is released.

Source files
------------

// File: rtl/gtfraw_vnc_status_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gtfraw_vnc_status_pkg
// Description : Shared types and helpers for the status-level qualifier.
// Revision    : 1.0 - initial release
// ============================================================================
package gtfraw_vnc_status_pkg;

    // Per-bit qualifier state: settled, or counting a candidate change.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } status_state_t;

    // Width of the glitch-filter counter; it must hold values up to STABLE_CYCLES.
    function automatic int filt_cnt_width(input int stable_cycles);
        if (stable_cycles < 1) begin
            return 1;
        end
        return $clog2(stable_cycles + 1);
    endfunction

endpackage : gtfraw_vnc_status_pkg
`default_nettype wire

// File: rtl/gtfraw_vnc_status_bit.sv
`default_nettype none
// ============================================================================
// Module      : gtfraw_vnc_status_bit
// Description : One status bit: glitch filter, rise/fall pulses, latched
//               low/high sticky bits and a saturating transition counter.
// Revision    : 1.0 - initial release
// ============================================================================
module gtfraw_vnc_status_bit
    import gtfraw_vnc_status_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_WIDTH     = 16,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 datain,
    input  logic                 stat_clear,
    output logic                 dataout,
    output logic                 rise,
    output logic                 fall,
    output logic                 sticky_low,
    output logic                 sticky_high,
    output logic [CNT_WIDTH-1:0] change_cnt
);

    localparam int                  c_FILT_W    = filt_cnt_width(STABLE_CYCLES);
    localparam logic [c_FILT_W-1:0] c_FILT_ONE  = c_FILT_W'(1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(STABLE_CYCLES - 1);

    status_state_t          r_state;
    logic [c_FILT_W-1:0]    r_filt_cnt;
    logic                   r_dataout;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_sticky_low;
    logic                   r_sticky_high;
    logic [CNT_WIDTH-1:0]   r_change_cnt;

    status_state_t          w_state_next;
    logic [c_FILT_W-1:0]    w_filt_next;
    logic                   w_commit;
    logic                   w_dataout_next;
    logic                   w_cnt_full;

    // Next-state logic: a change commits only after STABLE_CYCLES consecutive differing samples.
    always_comb begin
        w_state_next = r_state;
        w_filt_next  = '0;
        w_commit     = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (datain != r_dataout) begin
                    if (STABLE_CYCLES == 1) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_next = ST_PENDING;
                        w_filt_next  = c_FILT_ONE;
                    end
                end
            end
            ST_PENDING: begin
                if (datain != r_dataout) begin
                    if (r_filt_cnt == c_FILT_LAST) begin
                        w_commit     = 1'b1;
                        w_state_next = ST_STABLE;
                    end else begin
                        w_filt_next  = r_filt_cnt + c_FILT_ONE;
                    end
                end else begin
                    // A matching sample rejects the candidate as a glitch.
                    w_state_next = ST_STABLE;
                end
            end
            default: begin
                w_state_next = ST_STABLE;
            end
        endcase
        w_dataout_next = w_commit ? datain : r_dataout;
        w_cnt_full     = &r_change_cnt;
    end

    // Registered state, qualified level, pulses, sticky bits and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_STABLE;
            r_filt_cnt    <= '0;
            r_dataout     <= RESET_VALUE;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_sticky_low  <= ~RESET_VALUE;
            r_sticky_high <= RESET_VALUE;
            r_change_cnt  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_filt_cnt    <= w_filt_next;
            r_dataout     <= w_dataout_next;
            r_rise        <= w_commit & datain;
            r_fall        <= w_commit & ~datain;
            // Clear first, then OR in the current level so a coincident event wins.
            r_sticky_low  <= (stat_clear ? 1'b0 : r_sticky_low)  | ~w_dataout_next;
            r_sticky_high <= (stat_clear ? 1'b0 : r_sticky_high) |  w_dataout_next;
            if (stat_clear) begin
                r_change_cnt <= w_commit ? CNT_WIDTH'(1) : '0;
            end else if (w_commit && !w_cnt_full) begin
                r_change_cnt <= r_change_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign dataout     = r_dataout;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign sticky_low  = r_sticky_low;
    assign sticky_high = r_sticky_high;
    assign change_cnt  = r_change_cnt;

endmodule : gtfraw_vnc_status_bit
`default_nettype wire

// File: rtl/gtfraw_vnc_status_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : gtfraw_vnc_status_qualifier
// Description : WIDTH independent status-bit qualifiers (debounce, pulses,
//               sticky bits, transition counters) for synchronized levels.
// Revision    : 1.0 - initial release
// ============================================================================
module gtfraw_vnc_status_qualifier
    import gtfraw_vnc_status_pkg::*;
#(
    parameter int   WIDTH         = 1,
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_WIDTH     = 16,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       stat_clear,
    output logic [WIDTH-1:0]           dataout,
    output logic [WIDTH-1:0]           rise,
    output logic [WIDTH-1:0]           fall,
    output logic [WIDTH-1:0]           sticky_low,
    output logic [WIDTH-1:0]           sticky_high,
    output logic [WIDTH*CNT_WIDTH-1:0] change_cnt
);

    // One qualifier per status bit; bits share only clock, reset and clear.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gtfraw_vnc_status_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_WIDTH     (CNT_WIDTH),
            .RESET_VALUE   (RESET_VALUE)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .datain      (datain[i]),
            .stat_clear  (stat_clear),
            .dataout     (dataout[i]),
            .rise        (rise[i]),
            .fall        (fall[i]),
            .sticky_low  (sticky_low[i]),
            .sticky_high (sticky_high[i]),
            .change_cnt  (change_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end : g_bit

endmodule : gtfraw_vnc_status_qualifier
`default_nettype wire
